// File: rtl/wbslave_pkg.sv
// rtl/wbslave_pkg.sv - shared FSM encoding, address map and IRQ bit positions for wbslave_regs
package wbslave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int ADDR_MAILBOX = 0;
  localparam int IRQ_BUSERR   = 0;
  localparam int IRQ_MAILBOX  = 1;

  function automatic int ADDR_IRQ_STATUS(input int nregs);
    return nregs - 2;
  endfunction

  function automatic int ADDR_IRQ_EN(input int nregs);
    return nregs - 1;
  endfunction

endpackage

// File: rtl/wbslave_regfile.sv
// rtl/wbslave_regfile.sv - scratch RAM, IRQ_STATUS (W1C, set wins) / IRQ_EN, read mux and INTR register
module wbslave_regfile
  import wbslave_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int NREGS = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic          i_set_buserr,
  input  logic [AW-1:0] i_adr,
  input  logic [DW-1:0] i_wdat,
  output logic [DW-1:0] o_rdata,
  output logic          o_intr
);

  localparam int NSCR = NREGS - 2;
  localparam int IW   = (NSCR > 1) ? $clog2(NSCR) : 1;
  localparam logic [AW-1:0] A_MBX = AW'(ADDR_MAILBOX);
  localparam logic [AW-1:0] A_STS = AW'(ADDR_IRQ_STATUS(NREGS));
  localparam logic [AW-1:0] A_EN  = AW'(ADDR_IRQ_EN(NREGS));

  logic [DW-1:0] r_mem [NSCR];
  logic [1:0]    r_irq_sts;
  logic [1:0]    r_irq_en;
  logic          r_intr;

  logic          w_scr_hit;
  logic [IW-1:0] w_idx;
  logic [1:0]    w_clr;
  logic [1:0]    w_set;

  assign w_scr_hit = (i_adr < A_STS);
  assign w_idx     = i_adr[IW-1:0];
  assign w_clr     = (i_wr_en && (i_adr == A_STS)) ? i_wdat[1:0] : 2'b00;

  always_comb begin
    w_set              = 2'b00;
    w_set[IRQ_BUSERR]  = i_set_buserr;
    w_set[IRQ_MAILBOX] = i_wr_en && (i_adr == A_MBX);
  end

  // OR-ing the set vector after the clear makes a coincident set win over W1C
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NSCR; i++) r_mem[i] <= '0;
      r_irq_sts <= 2'b00;
      r_irq_en  <= 2'b00;
      r_intr    <= 1'b0;
    end else begin
      if (i_wr_en && w_scr_hit) r_mem[w_idx] <= i_wdat;
      if (i_wr_en && (i_adr == A_EN)) r_irq_en <= i_wdat[1:0];
      r_irq_sts <= (r_irq_sts & ~w_clr) | w_set;
      r_intr    <= |(r_irq_sts & r_irq_en);
    end
  end

  always_comb begin
    o_rdata = '0;
    if (w_scr_hit)           o_rdata = r_mem[w_idx];
    else if (i_adr == A_STS) o_rdata = DW'(r_irq_sts);
    else if (i_adr == A_EN)  o_rdata = DW'(r_irq_en);
  end

  assign o_intr = r_intr;

endmodule

// File: rtl/wbslave_regs.sv
// rtl/wbslave_regs.sv - Wishbone slave: request FSM, wait-state counter and address/SEL error decode
module wbslave_regs
  import wbslave_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int SW          = 1,
  parameter int NREGS       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [AW-1:0] ADR_I,
  input  logic [DW-1:0] DAT_I,
  output logic [DW-1:0] DAT_O,
  input  logic          WE_I,
  input  logic [SW-1:0] SEL_I,
  input  logic          STB_I,
  input  logic          CYC_I,
  output logic          ACK_O,
  output logic          ERR_O,
  output logic          INTR_O
);

  localparam int CW = 4;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_dat;
  logic [DW-1:0] r_dat_o;
  logic          r_we;
  logic          r_err;
  logic          r_ack;
  logic          r_erro;

  logic          w_req;
  logic          w_dec_err;
  logic          w_commit;
  logic          w_set_buserr;
  logic [DW-1:0] w_rdata;

  assign w_req        = CYC_I & STB_I;
  assign w_dec_err    = ({1'b0, ADR_I} >= (AW+1)'(NREGS)) || (SEL_I == '0);
  assign w_commit     = (r_state == ST_RESP) && r_we && !r_err;
  assign w_set_buserr = (r_state == ST_RESP) && r_err;

  // ACK/ERR/DAT_O are registered on the edge that leaves RESP, so the
  // response is visible during the first IDLE cycle after RESP.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_ack   <= 1'b0;
      r_erro  <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_ack  <= 1'b0;
      r_erro <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_adr <= ADR_I;
            r_dat <= DAT_I;
            r_we  <= WE_I;
            r_err <= w_dec_err;
            if (WAIT_STATES > 0) begin
              r_state <= ST_WAIT;
              r_cnt   <= CW'(WAIT_STATES - 1);
            end else begin
              r_state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (!w_req)             r_state <= ST_IDLE;
          else if (r_cnt == '0)   r_state <= ST_RESP;
          else                    r_cnt   <= r_cnt - 1'b1;
        end
        ST_RESP: begin
          r_ack   <= !r_err;
          r_erro  <= r_err;
          if (!r_err && !r_we) r_dat_o <= w_rdata;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  wbslave_regfile #(
    .AW    (AW),
    .DW    (DW),
    .NREGS (NREGS)
  ) u_regfile (
    .i_clk        (CLK_I),
    .i_rst_n      (RST_I),
    .i_wr_en      (w_commit),
    .i_set_buserr (w_set_buserr),
    .i_adr        (r_adr),
    .i_wdat       (r_dat),
    .o_rdata      (w_rdata),
    .o_intr       (INTR_O)
  );

  assign DAT_O = r_dat_o;
  assign ACK_O = r_ack;
  assign ERR_O = r_erro;

endmodule

// File: tb/tb_wbslave_regs.sv
// tb/tb_wbslave_regs.sv - scoreboard bench for wbslave_regs with one-wait and three-wait instances
module tb_wbslave_regs;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic [7:0] adr   [2];
  logic [7:0] dat_i [2];
  logic       we    [2];
  logic       sel   [2];
  logic       stb   [2];
  logic       cyc   [2];
  logic [7:0] dat_o [2];
  logic       ack   [2];
  logic       err   [2];
  logic       intr  [2];

  int cycn   = 0;
  int n_vec  = 0;
  int n_bad  = 0;

  typedef struct {
    int         cyc;
    bit         err;
    bit         chk;
    logic [7:0] dat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always @(posedge clk) cycn <= cycn + 1;

  wbslave_regs #(.AW(8), .DW(8), .SW(1), .NREGS(16), .WAIT_STATES(1)) u_dut0 (
    .CLK_I(clk), .RST_I(rst_n[0]), .ADR_I(adr[0]), .DAT_I(dat_i[0]), .DAT_O(dat_o[0]),
    .WE_I(we[0]), .SEL_I(sel[0]), .STB_I(stb[0]), .CYC_I(cyc[0]),
    .ACK_O(ack[0]), .ERR_O(err[0]), .INTR_O(intr[0])
  );

  wbslave_regs #(.AW(8), .DW(8), .SW(1), .NREGS(16), .WAIT_STATES(3)) u_dut1 (
    .CLK_I(clk), .RST_I(rst_n[1]), .ADR_I(adr[1]), .DAT_I(dat_i[1]), .DAT_O(dat_o[1]),
    .WE_I(we[1]), .SEL_I(sel[1]), .STB_I(stb[1]), .CYC_I(cyc[1]),
    .ACK_O(ack[1]), .ERR_O(err[1]), .INTR_O(intr[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every response pulse is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int k = 0; k < 2; k++) begin
      if (ack[k] || err[k]) begin
        have = 1'b0;
        if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        check($sformatf("ack_err_exclusive%0d", k), {31'b0, ack[k] & err[k]}, 0);
        if (!have) begin
          check($sformatf("unexpected_resp%0d", k), 1, 0);
        end else begin
          check($sformatf("resp_cycle%0d", k), cycn, e.cyc);
          check($sformatf("err%0d", k), {31'b0, err[k]}, {31'b0, e.err});
          check($sformatf("ack%0d", k), {31'b0, ack[k]}, {31'b0, !e.err});
          if (e.chk) check($sformatf("rdata%0d", k), {24'b0, dat_o[k]}, {24'b0, e.dat});
        end
      end
    end
  end

  task automatic xfer(input int k, input bit w, input logic [7:0] a, input logic [7:0] d,
                      input logic s, input bit e_err, input logic [7:0] e_dat);
    exp_t e;
    int   n;
    @(negedge clk);
    e.cyc = cycn + 2 + ((k == 0) ? 1 : 3);
    e.err = e_err;
    e.chk = !w && !e_err;
    e.dat = e_dat;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    adr[k] = a; dat_i[k] = d; we[k] = w; sel[k] = s; stb[k] = 1'b1; cyc[k] = 1'b1;
    @(negedge clk);
    adr[k] = ~a; dat_i[k] = ~d; we[k] = ~w;
    n = 1;
    while (!(ack[k] || err[k]) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check($sformatf("timeout%0d", k), 1, 0);
    stb[k] = 1'b0; cyc[k] = 1'b0;
  endtask

  task automatic wr(input int k, input logic [7:0] a, input logic [7:0] d);
    xfer(k, 1'b1, a, d, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic rd(input int k, input logic [7:0] a, input logic [7:0] exp);
    xfer(k, 1'b0, a, 8'h00, 1'b1, 1'b0, exp);
  endtask

  task automatic chk_outs_zero(input int k, input string tag);
    check({tag, "_dat_o"}, {24'b0, dat_o[k]}, 0);
    check({tag, "_ack"},   {31'b0, ack[k]}, 0);
    check({tag, "_err"},   {31'b0, err[k]}, 0);
    check({tag, "_intr"},  {31'b0, intr[k]}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; adr[k] = 8'h00; dat_i[k] = 8'h00; we[k] = 1'b0;
      sel[k] = 1'b1; stb[k] = 1'b0; cyc[k] = 1'b0;
    end
    #12;
    chk_outs_zero(0, "rst0");
    chk_outs_zero(1, "rst1");
    #3;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_ack0", {31'b0, ack[0]}, 0);
      check("idle_err0", {31'b0, err[0]}, 0);
    end

    wr(0, 8'd3, 8'hF0);
    rd(0, 8'd3, 8'hF0);

    wr(0, 8'd15, 8'h01);
    xfer(0, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1, 8'h00);
    check("intr_same_cycle_as_err", {31'b0, intr[0]}, 0);
    @(negedge clk);
    check("intr_after_err", {31'b0, intr[0]}, 1);
    rd(0, 8'd14, 8'h01);
    wr(0, 8'd14, 8'h01);
    check("intr_at_clear_ack", {31'b0, intr[0]}, 1);
    @(negedge clk);
    check("intr_after_clear", {31'b0, intr[0]}, 0);
    rd(0, 8'd14, 8'h00);

    wr(0, 8'd15, 8'h02);
    wr(0, 8'd0, 8'h55);
    rd(0, 8'd14, 8'h02);
    check("intr_mailbox", {31'b0, intr[0]}, 1);
    rd(0, 8'd0, 8'h55);

    xfer(0, 1'b1, 8'd4, 8'h99, 1'b0, 1'b1, 8'h00);
    rd(0, 8'd4, 8'h00);
    rd(0, 8'd14, 8'h03);
    wr(0, 8'd15, 8'hFE);
    rd(0, 8'd15, 8'h02);
    wr(0, 8'd14, 8'hFF);
    rd(0, 8'd14, 8'h00);
    check("intr_all_cleared", {31'b0, intr[0]}, 0);
    wr(0, 8'd13, 8'h5A);
    rd(0, 8'd13, 8'h5A);
    xfer(0, 1'b0, 8'd16, 8'h00, 1'b1, 1'b1, 8'h00);

    // Abort: STB dropped after one wait cycle of a three-wait write
    @(negedge clk);
    adr[1] = 8'd5; dat_i[1] = 8'hAA; we[1] = 1'b1; sel[1] = 1'b1; stb[1] = 1'b1; cyc[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stb[1] = 1'b0; cyc[1] = 1'b0;
    repeat (8) @(negedge clk);
    rd(1, 8'd5, 8'h00);

    wr(1, 8'd15, 8'h01);
    xfer(1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b1, 8'h00);
    wr(1, 8'd1, 8'h3C);
    rd(1, 8'd1, 8'h3C);
    check("intr1_before_reset", {31'b0, intr[1]}, 1);

    // Reset in the middle of the WAIT phase of a write
    @(negedge clk);
    adr[1] = 8'd2; dat_i[1] = 8'h77; we[1] = 1'b1; sel[1] = 1'b1; stb[1] = 1'b1; cyc[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n[1] = 1'b0; stb[1] = 1'b0; cyc[1] = 1'b0;
    #1;
    chk_outs_zero(1, "midrst");
    @(negedge clk);
    rst_n[1] = 1'b1;
    rd(1, 8'd2, 8'h00);
    rd(1, 8'd1, 8'h00);
    rd(1, 8'd15, 8'h00);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
